sc_div_mc: RTL and testbench
============================

SC_DIV_MC -- requirements
Module: sc_div_mc

Interface
REQ-001 Parameter W, default 6: counter and random-number width, W >= 2.
REQ-002 Parameter LANES, default 4: number of independent divider lanes, LANES >= 1.
REQ-003 Parameter INIT, default 2**(W-1): counter value after reset or clear, 0 <= INIT <= 2**W-1.
REQ-004 clk  input  1  clock, all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 en  input  1  advance enable; 0 = all state holds.
REQ-007 clr  input  1  synchronous reinitialise of all lanes.
REQ-008 bipolar  input  1  mode: 0 = unipolar, 1 = bipolar; quasi-static, changed only with clr asserted.
REQ-009 rand_num  input  W  shared comparison random number, all lanes.
REQ-010 dividend  input  LANES  dividend stochastic bit per lane.
REQ-011 divisor  input  LANES  divisor stochastic bit per lane.
REQ-012 quotient  output  LANES  quotient stochastic bit per lane.
REQ-013 cnt_o  output  LANES*W  lane counters, lane i at bits [i*W +: W].
REQ-014 sat_hi  output  LANES  lane counter equals 2**W-1.
REQ-015 sat_lo  output  LANES  lane counter equals 0.

Function
REQ-016 Per lane: quotient[i] SHALL be combinational: 1 iff cnt[i] >= rand_num (unsigned).
REQ-017 Per lane: q_d1[i] SHALL register quotient[i] on each clock with en=1.
REQ-018 Feedback product: p[i] = q_d1[i] & divisor[i] when bipolar=0; p[i] = ~(q_d1[i] ^ divisor[i]) when bipolar=1.
REQ-019 inc[i] = dividend[i] & ~p[i]; dec[i] = ~dividend[i] & p[i]; both 0 when dividend[i] == p[i].
REQ-020 With en=1, cnt[i] SHALL increment on inc[i] unless cnt[i] == 2**W-1.
REQ-021 With en=1, cnt[i] SHALL decrement on dec[i] unless cnt[i] == 0.
REQ-022 Counters SHALL saturate, never wrap; a blocked step leaves the counter and all flags unchanged.
REQ-023 clr=1 SHALL set every cnt to INIT and every q_d1 to 0 on the next edge, regardless of en.
REQ-024 en=0 and clr=0: cnt and q_d1 SHALL hold; quotient still follows rand_num combinationally.
REQ-025 Latency: a dividend/divisor bit affects cnt one edge later; quotient reflects the new cnt in the same cycle it updates.
REQ-026 Lanes SHALL be fully independent except for shared clk, rst_n, en, clr, bipolar, rand_num.
REQ-027 sat_hi/sat_lo SHALL be combinational decodes of the current cnt.

Reset
REQ-028 rst_n=0 SHALL asynchronously set every cnt to INIT and every q_d1 to 0.
REQ-029 During reset: cnt_o = INIT per lane; sat flags decode INIT; quotient = (INIT >= rand_num).
REQ-030 Reset mid-stream SHALL discard all accumulated state, with no partial update on the release edge.

Structure
REQ-031 Shared package sc_pkg SHALL hold the mode enum (SC_UNIPOLAR=0, SC_BIPOLAR=1) and the default-width constant (6).
REQ-032 One sub-module sc_div_lane (counter, q_d1, feedback, compare, flags) SHALL be instantiated LANES times via generate.
REQ-033 Top level SHALL contain only fan-out, concatenation of cnt_o, and parameter pass-through.

Verification
REQ-034 W=6, INIT=32: hold rst_n low, drive rand_num=40 -> cnt_o lanes = 32, quotient=0, sat flags 0; release, en=0 for 5 cycles -> no change.
REQ-035 Unipolar, lane 0: dividend=1, divisor=0 for 40 cycles -> cnt rises 32..63, stops at 63, sat_hi[0]=1, no wrap.
REQ-036 Unipolar, lane 0: dividend=0, divisor=1, rand_num=0 (q_d1=1) -> cnt falls to 0, sat_lo[0]=1, no wrap to 63.
REQ-037 Unipolar, Bernoulli dividend p=0.25, divisor p=0.5, LFSR rand_num, 4096 cycles -> quotient ones density 0.5 +/- 0.05.
REQ-038 Bipolar, dividend bipolar value -0.25 (p=0.375), divisor bipolar value 0.5 (p=0.75), 4096 cycles -> quotient bipolar value -0.5 +/- 0.1 (ones density 0.25 +/- 0.05).
REQ-039 Lanes 0..3 with distinct streams, clr pulsed at cycle 100 with en=1 -> all cnt = 32, q_d1 = 0 next cycle; lanes never cross-couple.

Source files
------------

// File: rtl/sc_pkg.sv
`timescale 1ns/1ps
// sc_pkg: shared definitions for the stochastic-computing divider blocks.
// Holds the unipolar/bipolar mode encoding, the default counter width and
// the feedback-product helper used by each divider lane.
package sc_pkg;

   // Stochastic number representation carried on the bit streams.
   typedef enum logic {
      SC_UNIPOLAR = 1'b0,
      SC_BIPOLAR  = 1'b1
   } sc_mode_e;

   // Default counter / random-number width.
   localparam int unsigned SC_DEFAULT_W = 6;

   // Stochastic product of the delayed quotient and the divisor stream.
   // Unipolar multiply is AND; bipolar multiply is XNOR.
   function automatic logic sc_feedback(input sc_mode_e mode,
                                        input logic     q,
                                        input logic     d);
      logic p;
      if (mode == SC_BIPOLAR) begin
         p = ~(q ^ d);
      end else begin
         p = q & d;
      end
      return p;
   endfunction

endpackage

// File: rtl/sc_div_lane.sv
`timescale 1ns/1ps
// sc_div_lane: one stochastic divider lane.
// A saturating up/down counter tracks the quotient value; it is compared
// against the shared random number to regenerate the quotient stream. The
// registered quotient is multiplied by the divisor stream and the product is
// steered toward the dividend stream by the counter, which closes the loop
// dividend = quotient * divisor.
module sc_div_lane
   import sc_pkg::*;
#(
   parameter int unsigned W    = SC_DEFAULT_W,
   parameter int unsigned INIT = 2**(W-1)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_en,
   input  logic         i_clr,
   input  logic         i_bipolar,
   input  logic [W-1:0] i_rand_num,
   input  logic         i_dividend,
   input  logic         i_divisor,
   output logic         o_quotient,
   output logic [W-1:0] o_cnt,
   output logic         o_sat_hi,
   output logic         o_sat_lo
);

   localparam logic [W-1:0] LP_INIT = W'(INIT);
   localparam logic [W-1:0] LP_MAX  = {W{1'b1}};
   localparam logic [W-1:0] LP_ONE  = W'(1);

   logic [W-1:0] r_cnt;
   logic         r_q_d1;

   sc_mode_e     w_mode;
   logic         w_quotient;
   logic         w_p;
   logic         w_inc;
   logic         w_dec;
   logic         w_sat_hi;
   logic         w_sat_lo;
   logic [W-1:0] w_cnt_nxt;

   // Compare, feedback product and step decode for the current cycle.
   always_comb begin
      w_mode     = sc_mode_e'(i_bipolar);
      w_quotient = (r_cnt >= i_rand_num);
      w_p        = sc_feedback(w_mode, r_q_d1, i_divisor);
      // Step only when dividend and product disagree.
      w_inc      = i_dividend & ~w_p;
      w_dec      = ~i_dividend & w_p;
      w_sat_hi   = (r_cnt == LP_MAX);
      w_sat_lo   = (r_cnt == '0);
   end

   // Saturating next-count: a blocked step leaves the counter untouched.
   always_comb begin
      w_cnt_nxt = r_cnt;
      if (w_inc && !w_sat_hi) begin
         w_cnt_nxt = r_cnt + LP_ONE;
      end else if (w_dec && !w_sat_lo) begin
         w_cnt_nxt = r_cnt - LP_ONE;
      end
   end

   // Counter and delayed-quotient state; clr overrides en.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt  <= LP_INIT;
         r_q_d1 <= 1'b0;
      end else if (i_clr) begin
         r_cnt  <= LP_INIT;
         r_q_d1 <= 1'b0;
      end else if (i_en) begin
         r_cnt  <= w_cnt_nxt;
         r_q_d1 <= w_quotient;
      end
   end

   // Outputs are direct decodes of the current state.
   always_comb begin
      o_quotient = w_quotient;
      o_cnt      = r_cnt;
      o_sat_hi   = w_sat_hi;
      o_sat_lo   = w_sat_lo;
   end

endmodule

// File: rtl/sc_div_mc.sv
`timescale 1ns/1ps
// sc_div_mc: multi-lane stochastic divider.
// Replicates sc_div_lane LANES times; lanes share only clock, reset, the
// enable/clear controls, the polarity mode and the comparison random number.
module sc_div_mc
   import sc_pkg::*;
#(
   parameter int unsigned W     = SC_DEFAULT_W,
   parameter int unsigned LANES = 4,
   parameter int unsigned INIT  = 2**(W-1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               en,
   input  logic               clr,
   input  logic               bipolar,
   input  logic [W-1:0]       rand_num,
   input  logic [LANES-1:0]   dividend,
   input  logic [LANES-1:0]   divisor,
   output logic [LANES-1:0]   quotient,
   output logic [LANES*W-1:0] cnt_o,
   output logic [LANES-1:0]   sat_hi,
   output logic [LANES-1:0]   sat_lo
);

   // One independent divider per lane; lane i owns cnt_o[i*W +: W].
   for (genvar g = 0; g < LANES; g++) begin : g_lane
      sc_div_lane #(
         .W    (W),
         .INIT (INIT)
      ) u_lane (
         .clk        (clk),
         .rst_n      (rst_n),
         .i_en       (en),
         .i_clr      (clr),
         .i_bipolar  (bipolar),
         .i_rand_num (rand_num),
         .i_dividend (dividend[g]),
         .i_divisor  (divisor[g]),
         .o_quotient (quotient[g]),
         .o_cnt      (cnt_o[g*W +: W]),
         .o_sat_hi   (sat_hi[g]),
         .o_sat_lo   (sat_lo[g])
      );
   end

endmodule

// File: tb/tb_sc_div_mc.sv
`timescale 1ns/1ps
// tb_sc_div_mc: scoreboard bench for sc_div_mc (W=6, LANES=4, INIT=32).
// Stimulus pushes expected values into a queue right after an edge; the
// monitor pops and compares on the following falling edge.
module tb_sc_div_mc;

   localparam int unsigned W     = 6;
   localparam int unsigned LANES = 4;
   localparam int unsigned INIT  = 32;
   localparam int WARM = 300;
   localparam int MEAS = 4096;

   localparam int K_CNT  = 0;
   localparam int K_CNT0 = 1;
   localparam int K_Q    = 2;
   localparam int K_SHI  = 3;
   localparam int K_SLO  = 4;
   localparam int K_DENS = 5;

   typedef struct {
      string       name;
      int          kind;
      logic [31:0] exp;
      int          lo;
      int          hi;
   } exp_t;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               en;
   logic               clr;
   logic               bipolar;
   logic [W-1:0]       rand_num;
   logic [LANES-1:0]   dividend;
   logic [LANES-1:0]   divisor;
   logic [LANES-1:0]   quotient;
   logic [LANES*W-1:0] cnt_o;
   logic [LANES-1:0]   sat_hi;
   logic [LANES-1:0]   sat_lo;

   exp_t      sb_q[$];
   int        n_tests = 0;
   int        n_fail  = 0;
   int        dens_ones = 0;
   int        dens_samples = 0;
   bit        meas_on = 1'b0;
   logic [5:0] lfsr = 6'h01;

   sc_div_mc #(
      .W     (W),
      .LANES (LANES),
      .INIT  (INIT)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .clr      (clr),
      .bipolar  (bipolar),
      .rand_num (rand_num),
      .dividend (dividend),
      .divisor  (divisor),
      .quotient (quotient),
      .cnt_o    (cnt_o),
      .sat_hi   (sat_hi),
      .sat_lo   (sat_lo)
   );

   always #5 clk = ~clk;

   // Advance one rising edge, land 2ns after it.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Input-change slot: just after a falling edge, after the monitor sampled.
   task automatic slot();
      @(negedge clk);
      #1;
   endtask

   function automatic void expect_val(input string nm, input int kind, input logic [31:0] v);
      exp_t e;
      e.name = nm;
      e.kind = kind;
      e.exp  = v;
      e.lo   = 0;
      e.hi   = 0;
      sb_q.push_back(e);
   endfunction

   function automatic void expect_range(input string nm, input int lo, input int hi);
      exp_t e;
      e.name = nm;
      e.kind = K_DENS;
      e.exp  = 32'd0;
      e.lo   = lo;
      e.hi   = hi;
      sb_q.push_back(e);
   endfunction

   function automatic logic [31:0] pack4(input int a0, input int a1, input int a2, input int a3);
      logic [23:0] p;
      p = {a3[5:0], a2[5:0], a1[5:0], a0[5:0]};
      return 32'(p);
   endfunction

   // Random streams per lane with probabilities given in eighths.
   task automatic run_density(input int unsigned pd8, input int unsigned ps8);
      for (int k = 0; k < WARM + MEAS; k++) begin
         slot();
         lfsr = {lfsr[4:0], lfsr[5] ^ lfsr[4]};
         rand_num = lfsr;
         for (int i = 0; i < LANES; i++) begin
            dividend[i] = ($urandom_range(0, 7) < pd8);
            divisor[i]  = ($urandom_range(0, 7) < ps8);
         end
         meas_on = (k >= WARM);
      end
      slot();
      meas_on = 1'b0;
      tick();
   endtask

   // Monitor: accumulate density windows and drain the scoreboard.
   initial begin
      exp_t        e;
      logic [31:0] act;
      bit          ok;
      forever begin
         @(negedge clk);
         if (meas_on) begin
            dens_ones    += $countones(quotient);
            dens_samples += LANES;
         end
         while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ok = 1'b0;
            act = 32'd0;
            case (e.kind)
               K_CNT:  begin act = 32'(cnt_o);        ok = (act == e.exp); end
               K_CNT0: begin act = 32'(cnt_o[W-1:0]); ok = (act == e.exp); end
               K_Q:    begin act = 32'(quotient);     ok = (act == e.exp); end
               K_SHI:  begin act = 32'(sat_hi);       ok = (act == e.exp); end
               K_SLO:  begin act = 32'(sat_lo);       ok = (act == e.exp); end
               default: begin
                  act = (dens_samples == 0) ? 32'd0 : 32'(dens_ones * 1000 / dens_samples);
                  ok  = (int'(act) >= e.lo) && (int'(act) <= e.hi);
                  dens_ones    = 0;
                  dens_samples = 0;
               end
            endcase
            n_tests++;
            if (!ok) begin
               n_fail++;
               if (e.kind == K_DENS) begin
                  $display("FAIL %s: got %0d permille, expected %0d..%0d permille",
                           e.name, act, e.lo, e.hi);
               end else begin
                  $display("FAIL %s: got 0x%0h, expected 0x%0h", e.name, act, e.exp);
               end
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   // Stimulus.
   initial begin
      rst_n    = 1'b0;
      en       = 1'b0;
      clr      = 1'b0;
      bipolar  = 1'b0;
      rand_num = 6'd40;
      dividend = '0;
      divisor  = '0;

      // Reset state: counters at INIT, 32 < 40 so quotient low.
      tick();
      expect_val("rst_cnt", K_CNT, pack4(32, 32, 32, 32));
      expect_val("rst_q",   K_Q,   32'd0);
      expect_val("rst_shi", K_SHI, 32'd0);
      expect_val("rst_slo", K_SLO, 32'd0);

      // Release with en=0: dividend active but nothing moves.
      slot();
      rst_n    = 1'b1;
      dividend = 4'b1111;
      repeat (5) tick();
      expect_val("hold_cnt", K_CNT, pack4(32, 32, 32, 32));
      expect_val("hold_q",   K_Q,   32'd0);

      // Unipolar ramp up on lane 0 (divisor 0 -> product 0 -> increment).
      slot();
      en       = 1'b1;
      dividend = 4'b0001;
      divisor  = 4'b0000;
      for (int n = 1; n <= 40; n++) begin
         tick();
         expect_val($sformatf("up_cnt0_%0d", n), K_CNT0, 32'((32 + n > 63) ? 63 : 32 + n));
         if (n == 7)  expect_val("up_q_39",   K_Q,   32'd0);
         if (n == 8)  expect_val("up_q_40",   K_Q,   32'b0001);
         if (n == 30) expect_val("up_shi_62", K_SHI, 32'd0);
         if (n == 31) expect_val("up_shi_63", K_SHI, 32'b0001);
      end
      expect_val("up_cnt", K_CNT, pack4(63, 32, 32, 32));
      expect_val("up_shi", K_SHI, 32'b0001);
      expect_val("up_slo", K_SLO, 32'd0);
      expect_val("up_q",   K_Q,   32'b0001);

      // Unipolar ramp down on lane 0: rand 0 keeps q_d1=1, product=1.
      slot();
      dividend = 4'b0000;
      divisor  = 4'b0001;
      rand_num = 6'd0;
      for (int n = 1; n <= 70; n++) begin
         tick();
         expect_val($sformatf("dn_cnt0_%0d", n), K_CNT0, 32'((63 - n < 0) ? 0 : 63 - n));
         if (n == 62) expect_val("dn_slo_1", K_SLO, 32'd0);
         if (n == 63) expect_val("dn_slo_0", K_SLO, 32'b0001);
      end
      expect_val("dn_cnt", K_CNT, pack4(0, 32, 32, 32));
      expect_val("dn_slo", K_SLO, 32'b0001);
      expect_val("dn_shi", K_SHI, 32'd0);
      expect_val("dn_q",   K_Q,   32'b1111);

      // Clear with en=0 still reinitialises; switch to bipolar.
      slot();
      en       = 1'b0;
      clr      = 1'b1;
      bipolar  = 1'b1;
      rand_num = 6'd63;
      divisor  = 4'b0000;
      tick();
      expect_val("clr_noen_cnt", K_CNT, pack4(32, 32, 32, 32));

      // Bipolar: lane0 (1,1) inc, lane1 (0,0) dec, lane2 (1,0) hold, lane3 (0,1) hold.
      slot();
      clr      = 1'b0;
      en       = 1'b1;
      dividend = 4'b0101;
      divisor  = 4'b1001;
      repeat (5) tick();
      expect_val("bip_cnt", K_CNT, pack4(37, 27, 32, 32));
      expect_val("bip_q",   K_Q,   32'd0);

      // en=0 holds state; quotient still tracks rand_num.
      slot();
      en       = 1'b0;
      rand_num = 6'd30;
      repeat (3) tick();
      expect_val("en0_cnt", K_CNT, pack4(37, 27, 32, 32));
      expect_val("en0_q",   K_Q,   32'b1101);

      // Asynchronous reset mid-stream.
      slot();
      rst_n    = 1'b0;
      en       = 1'b1;
      rand_num = 6'd20;
      #1;
      expect_val("mid_rst_cnt", K_CNT, pack4(32, 32, 32, 32));
      expect_val("mid_rst_q",   K_Q,   32'b1111);
      slot();
      rst_n    = 1'b1;
      rand_num = 6'd63;
      tick();
      expect_val("post_rst_cnt", K_CNT, pack4(33, 31, 32, 32));

      // Multi-lane unipolar with clr pulse.
      slot();
      clr      = 1'b1;
      bipolar  = 1'b0;
      rand_num = 6'd0;
      tick();
      expect_val("ml_clr0_cnt", K_CNT, pack4(32, 32, 32, 32));
      slot();
      clr      = 1'b0;
      dividend = 4'b0101;
      divisor  = 4'b0110;
      repeat (10) tick();
      expect_val("ml_cnt",  K_CNT, pack4(42, 23, 33, 32));
      expect_val("ml_q",    K_Q,   32'b1111);
      slot();
      clr = 1'b1;
      tick();
      expect_val("ml_clr_cnt", K_CNT, pack4(32, 32, 32, 32));
      slot();
      clr = 1'b0;
      tick();
      expect_val("ml_after1", K_CNT, pack4(33, 32, 33, 32));
      tick();
      expect_val("ml_after2", K_CNT, pack4(34, 31, 33, 32));

      // Unipolar density: 0.25 / 0.5 -> 0.5.
      slot();
      clr     = 1'b1;
      bipolar = 1'b0;
      tick();
      slot();
      clr = 1'b0;
      run_density(2, 4);
      expect_range("uni_density", 450, 550);

      // Bipolar density: -0.25 / 0.5 -> -0.5 (ones 0.25).
      slot();
      clr     = 1'b1;
      bipolar = 1'b1;
      tick();
      slot();
      clr = 1'b0;
      run_density(3, 6);
      expect_range("bip_density", 200, 300);

      tick();
      tick();
      n_tests++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL sb_drain: got %0d pending, expected 0", sb_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
